button_conditioner: RTL and testbench

Conditions the raw iCEBreaker push-button inputs before they reach the stopwatch control logic. Per button: two-flop synchronisation, polarity normalisation, counter-based debounce, one-cycle press/release strobes, and a long-press/auto-repeat strobe. The stopwatch top consumes `press` (start/stop/lap/clear) and `hold` (fast-set) instead of sampling `BTN_N`/`BTN1..3` levels directly.

---
 rtl/button_conditioner_pkg.sv | 35 +++
 rtl/button_debounce_ch.sv | 129 ++++++++++++
 rtl/button_conditioner.sv | 41 ++++
 tb/tb_button_conditioner.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared clock-derived defaults, debounce FSM encoding and counter sizing helpers
// for the push-button conditioner.
package button_conditioner_pkg;

    localparam int CLK_HZ      = 12000000;
    localparam int CYC_PER_MS  = CLK_HZ / 1000;
    localparam int CYC_PER_S   = CLK_HZ;

    localparam int DEF_DEBOUNCE_CYCLES = 10 * CYC_PER_MS;
    localparam int DEF_LONG_CYCLES     = CYC_PER_S;
    localparam int DEF_REPEAT_CYCLES   = 200 * CYC_PER_MS;

    localparam logic [1:0] ENC_RELEASED  = 2'd0;
    localparam logic [1:0] ENC_PRESSING  = 2'd1;
    localparam logic [1:0] ENC_PRESSED   = 2'd2;
    localparam logic [1:0] ENC_RELEASING = 2'd3;

    typedef enum logic [1:0] {
        ST_RELEASED  = ENC_RELEASED,
        ST_PRESSING  = ENC_PRESSING,
        ST_PRESSED   = ENC_PRESSED,
        ST_RELEASING = ENC_RELEASING
    } btn_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: two-flop sync, debounce FSM, press/release strobes and
// long-press/auto-repeat hold strobe. All outputs registered.
module button_debounce_ch
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_hold
);

    localparam int CW = cnt_width(max3(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES));
    // The edge that leaves the stable state already counts as the first of the run.
    localparam logic [CW-1:0] DCNT_LAST = CW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    btn_state_e    r_state;
    logic          r_s1, r_s2;
    logic [CW-1:0] r_dcnt;
    logic [CW-1:0] r_hcnt;
    logic          r_rep;
    logic          r_hdone;
    logic          r_level, r_press, r_release, r_hold;

    logic w_rise, w_fall, w_hold_hit;

    always_comb begin
        w_rise = 1'b0;
        w_fall = 1'b0;
        case (r_state)
            ST_RELEASED:  w_rise = r_s2 && (DEBOUNCE_CYCLES == 1);
            ST_PRESSING:  w_rise = r_s2 && (r_dcnt == DCNT_LAST);
            ST_PRESSED:   w_fall = !r_s2 && (DEBOUNCE_CYCLES == 1);
            ST_RELEASING: w_fall = !r_s2 && (r_dcnt == DCNT_LAST);
            default:      ;
        endcase
        w_hold_hit = r_level && !w_fall && !r_hdone &&
                     (r_rep ? (r_hcnt == REP_LAST) : (r_hcnt == LONG_LAST));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_RELEASED;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_dcnt    <= '0;
            r_hcnt    <= '0;
            r_rep     <= 1'b0;
            r_hdone   <= 1'b0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_hold    <= 1'b0;
        end else begin
            r_s1      <= i_btn;
            r_s2      <= r_s1;
            r_press   <= w_rise;
            r_release <= w_fall;
            r_hold    <= w_hold_hit;

            if (w_rise) begin
                r_state <= ST_PRESSED;
                r_level <= 1'b1;
                r_dcnt  <= '0;
            end else if (w_fall) begin
                r_state <= ST_RELEASED;
                r_level <= 1'b0;
                r_dcnt  <= '0;
            end else begin
                case (r_state)
                    ST_RELEASED: begin
                        if (r_s2) r_state <= ST_PRESSING;
                        r_dcnt <= '0;
                    end
                    ST_PRESSING: begin
                        if (!r_s2) begin
                            r_state <= ST_RELEASED;
                            r_dcnt  <= '0;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (!r_s2) r_state <= ST_RELEASING;
                        r_dcnt <= '0;
                    end
                    ST_RELEASING: begin
                        if (r_s2) begin
                            r_state <= ST_PRESSED;
                            r_dcnt  <= '0;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_RELEASED;
                endcase
            end

            // Hold timing restarts on every level change and idles once a non-repeating hold fired.
            if (w_rise || w_fall) begin
                r_hcnt  <= '0;
                r_rep   <= 1'b0;
                r_hdone <= 1'b0;
            end else if (r_level && !r_hdone) begin
                if (w_hold_hit) begin
                    r_hcnt <= '0;
                    if (REPEAT_CYCLES == 0) r_hdone <= 1'b1;
                    else                    r_rep   <= 1'b1;
                end else begin
                    r_hcnt <= r_hcnt + 1'b1;
                end
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_hold    = r_hold;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-button pads into debounced levels and one-cycle
// press/release/hold strobes; INVERT marks active-low pads.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int               N_BTN           = 4,
    parameter logic [N_BTN-1:0] INVERT          = N_BTN'(1),
    parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int               LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int               REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_btn_raw,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_hold
);

    logic [N_BTN-1:0] w_norm;

    assign w_norm = i_btn_raw ^ INVERT;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_btn     (w_norm[g]),
            .o_level   (o_level[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_hold    (o_hold[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench: behavioural model predicts each edge's outputs for a
// repeating (REPEAT=3) and a single-hold (REPEAT=0) instance.
module tb_button_conditioner;

    localparam int         DEB  = 4;
    localparam int         LONG = 10;
    localparam int         REP  = 3;
    localparam logic [3:0] INV  = 4'b0001;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] a_level, a_press, a_release, a_hold;
    logic [3:0] b_level, b_press, b_release, b_hold;

    always #5 clk = ~clk;

    button_conditioner #(.N_BTN(4), .INVERT(INV), .DEBOUNCE_CYCLES(DEB),
                         .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)) dut (
        .i_clk(clk), .i_rst(rst), .i_btn_raw(btn_raw),
        .o_level(a_level), .o_press(a_press), .o_release(a_release), .o_hold(a_hold));

    button_conditioner #(.N_BTN(4), .INVERT(INV), .DEBOUNCE_CYCLES(DEB),
                         .LONG_CYCLES(LONG), .REPEAT_CYCLES(0)) dut_r0 (
        .i_clk(clk), .i_rst(rst), .i_btn_raw(btn_raw),
        .o_level(b_level), .o_press(b_press), .o_release(b_release), .o_hold(b_hold));

    int n_tests = 0;
    int n_fail  = 0;

    // Expected word per edge: instance i occupies bits [16*i +: 16] = {hold, release, press, level}.
    logic [31:0] exp_q[$];

    int   m_edge = 0;
    logic m_s1 [2][4];
    logic m_s2 [2][4];
    logic m_lvl[2][4];
    int   m_run[2][4];
    int   m_pe [2][4];

    int cnt_press2 = 0, cnt_hold3 = 0, cnt_hold1_r0 = 0;

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Spec-level model: the synchronised value seen at an edge is the pad sampled two edges
    // earlier; level flips after DEB consecutive disagreeing edges; hold is pure arithmetic
    // on the distance from the press edge.
    task automatic model_edge(input logic r, input logic [3:0] raw, output logic [31:0] e);
        logic [3:0] norm;
        logic       seen;
        int         k, rp;
        norm = raw ^ INV;
        e = '0;
        m_edge++;
        for (int i = 0; i < 2; i++) begin
            rp = (i == 0) ? REP : 0;
            for (int c = 0; c < 4; c++) begin
                if (r) begin
                    m_s1[i][c] = 1'b0; m_s2[i][c] = 1'b0; m_lvl[i][c] = 1'b0;
                    m_run[i][c] = 0;   m_pe[i][c] = 0;
                end else begin
                    seen = m_s2[i][c];
                    m_s2[i][c] = m_s1[i][c];
                    m_s1[i][c] = norm[c];
                    if (seen != m_lvl[i][c]) m_run[i][c]++;
                    else                     m_run[i][c] = 0;
                    if (m_run[i][c] == DEB) begin
                        m_run[i][c] = 0;
                        m_lvl[i][c] = !m_lvl[i][c];
                        if (m_lvl[i][c]) begin
                            e[16*i + 4 + c] = 1'b1;
                            m_pe[i][c] = m_edge;
                        end else begin
                            e[16*i + 8 + c] = 1'b1;
                        end
                    end else if (m_lvl[i][c]) begin
                        k = m_edge - m_pe[i][c];
                        if (k == LONG || (rp > 0 && k > LONG && (k - LONG) % rp == 0))
                            e[16*i + 12 + c] = 1'b1;
                    end
                    e[16*i + c] = m_lvl[i][c];
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] raw, input logic r);
        logic [31:0] e;
        btn_raw = raw;
        rst     = r;
        model_edge(r, raw, e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic steps(input logic [3:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0);
    endtask

    // Monitor: one scoreboard entry per rising edge, sampled 1 time unit after it.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            cnt_press2   += int'(a_press[2]);
            cnt_hold3    += int'(a_hold[3]);
            cnt_hold1_r0 += int'(b_hold[1]);
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("outputs_rep3", int'({a_hold, a_release, a_press, a_level}), int'(e[15:0]));
                check("outputs_rep0", int'({b_hold, b_release, b_press, b_level}), int'(e[31:16]));
            end
        end
    end

    initial begin
        int s0;
        logic [3:0] cur;

        // Reset with bit 0 pad low (pressed), then release reset: press on ch0 only after debounce.
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
        steps(4'b0000, 8);
        steps(4'b0001, 8);

        // Clean press and release on ch1.
        steps(4'b0011, 8);
        steps(4'b0001, 8);

        // Bounce on ch2: exactly one press.
        s0 = cnt_press2;
        steps(4'b0101, 3);
        steps(4'b0001, 1);
        steps(4'b0101, 8);
        steps(4'b0001, 8);
        check("bounce_single_press", cnt_press2 - s0, 1);

        // Long hold on ch3: holds at p+10,13,16,19; the one due on the release edge is suppressed.
        s0 = cnt_hold3;
        steps(4'b1001, 22);
        steps(4'b0001, 10);
        check("hold_repeat_count", cnt_hold3 - s0, 4);

        // Reset pulse mid-hold on ch1, button kept pressed through deassertion.
        steps(4'b0011, 11);
        step(4'b0011, 1'b1);
        steps(4'b0011, 10);
        steps(4'b0001, 8);

        // Simultaneous press on ch1 and ch2; the REPEAT=0 instance emits a single hold.
        s0 = cnt_hold1_r0;
        steps(4'b0111, 20);
        steps(4'b0001, 10);
        check("rep0_single_hold", cnt_hold1_r0 - s0, 1);

        // Randomised pad activity with occasional reset pulses.
        cur = 4'b0001;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) cur[$urandom_range(0, 3)] ^= 1'b1;
            step(cur, ($urandom_range(0, 249) == 0));
        end
        steps(4'b0001, 12);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
